// File: rtl/axis_pkg.sv
// Shared types and constants for the AXIS packet arbiter slice.
package axis_pkg;
  // Arbiter states: idle, or locked to one source until its tlast beat
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int         NUM_SRC   = 2;
  localparam int         DEST_W    = 2;
  localparam logic [7:0] TID_VALUE = 8'd0;
endpackage

// File: rtl/axis_packet_arbiter_if.sv
// AXI4-Stream bundle; the slave view carries only what the arbiter consumes.
interface axis_packet_arbiter_if
  import axis_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic                tvalid;
  logic                tready;
  logic [DATA_W-1:0]   tdata;
  logic                tlast;
  logic [DEST_W-1:0]   tdest;
  logic [DATA_W/8-1:0] tkeep;
  logic [DATA_W/8-1:0] tstrb;
  logic [7:0]          tid;

  modport master (output tvalid, tdata, tlast, tdest, tkeep, tstrb, tid, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_reg_slice.sv
// Single-stage forward register slice; holds its beat while downstream stalls.
module axis_reg_slice
  import axis_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [DEST_W-1:0] in_dest,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DEST_W-1:0] out_dest,
  input  logic              out_ready
);
  // Slot is free when empty or being drained this cycle
  assign in_ready = ~out_valid | out_ready;

  // Load a new beat whenever the slot frees; payload only changes on a real beat
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_dest  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
        out_dest <= in_dest;
      end
    end
  end
endmodule

// File: rtl/axis_packet_arbiter.sv
// Two-source packet-level round-robin AXIS arbiter with per-source packet counters.
module axis_packet_arbiter
  import axis_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_SRC-1:0]    src_en,
  axis_packet_arbiter_if.slave  s0_axis,
  axis_packet_arbiter_if.slave  s1_axis,
  axis_packet_arbiter_if.master m_axis,
  output logic [NUM_SRC-1:0]    grant,
  output logic [CNT_W-1:0]      pkt_cnt0,
  output logic [CNT_W-1:0]      pkt_cnt1
);
  arb_state_t state;
  logic       last_src;     // index of the most recently granted source
  logic       slice_ready;
  logic       hs0, hs1;
  logic [1:0] elig;
  logic       in_valid;
  logic [DATA_W-1:0] in_data;
  logic       in_last;
  logic [DEST_W-1:0] in_dest;
  logic       m_last_hs;

  assign elig[0] = s0_axis.tvalid & src_en[0];
  assign elig[1] = s1_axis.tvalid & src_en[1];

  // grant is one-hot, so it alone selects the source allowed to move data
  assign s0_axis.tready = aresetn & grant[0] & slice_ready;
  assign s1_axis.tready = aresetn & grant[1] & slice_ready;
  assign hs0 = s0_axis.tvalid & s0_axis.tready;
  assign hs1 = s1_axis.tvalid & s1_axis.tready;

  assign in_valid = hs0 | hs1;
  assign in_data  = grant[1] ? s1_axis.tdata : s0_axis.tdata;
  assign in_last  = grant[1] ? s1_axis.tlast : s0_axis.tlast;
  assign in_dest  = grant[1] ? DEST_W'(1) : DEST_W'(0);

  assign m_axis.tkeep = '1;
  assign m_axis.tstrb = '1;
  assign m_axis.tid   = TID_VALUE;

  axis_reg_slice #(.DATA_W(DATA_W)) u_slice (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_dest   (in_dest),
    .in_ready  (slice_ready),
    .out_valid (m_axis.tvalid),
    .out_data  (m_axis.tdata),
    .out_last  (m_axis.tlast),
    .out_dest  (m_axis.tdest),
    .out_ready (m_axis.tready)
  );

  // Arbitrate in IDLE, hold the lock until the owner's tlast beat is accepted;
  // src_en is only consulted at grant time so a packet in flight always completes
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= IDLE;
      grant    <= '0;
      last_src <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (elig[0] && (!elig[1] || last_src)) begin
            state    <= LOCK0;
            grant    <= 2'b01;
            last_src <= 1'b0;
          end else if (elig[1]) begin
            state    <= LOCK1;
            grant    <= 2'b10;
            last_src <= 1'b1;
          end
        end
        LOCK0: if (hs0 && s0_axis.tlast) begin
          state <= IDLE;
          grant <= '0;
        end
        LOCK1: if (hs1 && s1_axis.tlast) begin
          state <= IDLE;
          grant <= '0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign m_last_hs = m_axis.tvalid & m_axis.tready & m_axis.tlast;

  // Count packets as they leave on the master side, wrapping naturally
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (m_last_hs) begin
      if (m_axis.tdest == DEST_W'(0)) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (m_axis.tdest == DEST_W'(1)) pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end
endmodule
